// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the branch-resolution sequencer: opcodes, branch conditions, FSM states.
// Instruction format assumed here: opcode in [15:12]; branches carry cond in [10:8] and imm in [7:0].
package branch_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NAND = 4'h2,
    OP_XOR  = 4'h3,
    OP_INC  = 4'h4,
    OP_B    = 4'hC
  } opcode_e;

  typedef enum logic [2:0] {
    COND_EQUAL            = 3'd0,
    COND_NOT_EQUAL        = 3'd1,
    COND_LESS             = 3'd2,
    COND_GREATER          = 3'd3,
    COND_GREATER_OR_EQUAL = 3'd4,
    COND_LESS_OR_EQUAL    = 3'd5,
    COND_OVERFLOW         = 3'd6,
    COND_TRUE             = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam int InstrWidth = 16;
  localparam int PcWidth    = 16;

  function automatic logic [3:0] get_opcode(input logic [InstrWidth-1:0] instr);
    return instr[15:12];
  endfunction

  // The all-zero ADD word is the NOP and leaves the flags alone.
  function automatic logic is_flag_writer(input logic [InstrWidth-1:0] instr);
    logic [3:0] op;
    op = get_opcode(instr);
    return ((op == OP_ADD) && (instr != '0)) ||
           (op == OP_SUB) || (op == OP_NAND) ||
           (op == OP_XOR) || (op == OP_INC);
  endfunction

  function automatic logic is_branch(input logic [InstrWidth-1:0] instr);
    return get_opcode(instr) == OP_B;
  endfunction

  function automatic logic [PcWidth-1:0] branch_target(input logic [PcWidth-1:0] pc,
                                                       input logic [7:0]         imm);
    logic [PcWidth-1:0] offset;
    offset = {{7{imm[7]}}, imm, 1'b0};
    return pc + 16'd2 + offset;
  endfunction

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// Combinational branch-condition evaluator over the Z/V/N flags.
module branch_cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       z_i,
  input  logic       v_i,
  input  logic       n_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQUAL:            taken_o = z_i;
      COND_NOT_EQUAL:        taken_o = ~z_i;
      COND_LESS:             taken_o = n_i & ~v_i;
      COND_GREATER:          taken_o = ~z_i & ~n_i & ~v_i;
      COND_GREATER_OR_EQUAL: taken_o = ~n_i & ~v_i;
      COND_LESS_OR_EQUAL:    taken_o = (n_i & ~v_i) | z_i;
      COND_OVERFLOW:         taken_o = v_i;
      COND_TRUE:             taken_o = 1'b1;
      default:               taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch-resolution sequencer: scoreboards in-flight flag writers, stalls branches until flags are final.
// Optional FLAG_BYPASS_EN lets a branch resolve on the committing writer's flags in the same cycle.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic [15:0] id_instr_i,
  input  logic [15:0] id_pc_i,
  output logic        id_ready_o,
  input  logic        wb_flag_valid_i,
  input  logic        wb_z_i,
  input  logic        wb_v_i,
  input  logic        wb_n_i,
  output logic        redirect_valid_o,
  output logic [15:0] redirect_pc_o,
  output logic        flush_o
);

  localparam int CntWidth = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CntWidth-1:0] PendMax = CntWidth'(MAX_INFLIGHT);
  localparam logic [CntWidth-1:0] PendOne = CntWidth'(1);

  state_e              state_q;
  logic [CntWidth-1:0] pending_q, pending_d;
  logic                z_q, v_q, n_q;
  logic                redirect_valid_q;
  logic                flush_q;
  logic [15:0]         redirect_pc_q;

  logic isBranch, isWriter, pendingZero, bypassHit, flagsReady;
  logic evalZ, evalV, evalN, taken;
  logic accept, incr, decr;
  logic [15:0] target;

  assign isBranch    = is_branch(id_instr_i);
  assign isWriter    = is_flag_writer(id_instr_i);
  assign pendingZero = (pending_q == '0);
  assign target      = branch_target(id_pc_i, id_instr_i[7:0]);

`ifdef FLAG_BYPASS_EN
  assign bypassHit = (pending_q == PendOne) && wb_flag_valid_i;
`else
  assign bypassHit = 1'b0;
`endif

  assign flagsReady = pendingZero || bypassHit;
  assign evalZ      = bypassHit ? wb_z_i : z_q;
  assign evalV      = bypassHit ? wb_v_i : v_q;
  assign evalN      = bypassHit ? wb_n_i : n_q;

  branch_cond_eval u_cond_eval (
    .cond_i  (id_instr_i[10:8]),
    .z_i     (evalZ),
    .v_i     (evalV),
    .n_i     (evalN),
    .taken_o (taken)
  );

  always_comb begin
    id_ready_o = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (isBranch)      id_ready_o = flagsReady;
          else if (isWriter) id_ready_o = (pending_q != PendMax);
          else               id_ready_o = 1'b1;
        end
        STALL:    id_ready_o = isBranch && flagsReady;
        REDIRECT: id_ready_o = 1'b0;
        default:  id_ready_o = 1'b0;
      endcase
    end
  end

  // Branches are never writers, so a stalled branch can only ever see decrements.
  assign accept = id_valid_i && id_ready_o;
  assign incr   = accept && isWriter;
  assign decr   = wb_flag_valid_i && !pendingZero;

  always_comb begin
    pending_d = pending_q;
    case ({incr, decr})
      2'b10:   pending_d = pending_q + PendOne;
      2'b01:   pending_d = pending_q - PendOne;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (wb_flag_valid_i) begin
        z_q <= wb_z_i;
        v_q <= wb_v_i;
        n_q <= wb_n_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
          if (id_valid_i && isBranch) begin
            if (!flagsReady) begin
              state_q <= STALL;
            end else if (taken) begin
              state_q          <= REDIRECT;
              redirect_valid_q <= 1'b1;
              flush_q          <= 1'b1;
              redirect_pc_q    <= target;
            end
          end
        end
        STALL: begin
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
          if (id_valid_i && isBranch && flagsReady) begin
            if (taken) begin
              state_q          <= REDIRECT;
              redirect_valid_q <= 1'b1;
              flush_q          <= 1'b1;
              redirect_pc_q    <= target;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        REDIRECT: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign flush_o          = flush_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule
